// File: rtl/stepper_pkg.sv
// Shared types, phase tables and helpers for the stepper step scheduler.
// Build macro STEPPER_HALF_STEP_EN selects the 8-entry half-step table; default is the 4-entry wave table.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int MIN_DELAY = 2;
  localparam int PHASE_W   = 3;

  // Entry 0 sits in the least-significant nibble.
  localparam logic [15:0] WAVE_TABLE = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [31:0] HALF_TABLE = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

`ifdef STEPPER_HALF_STEP_EN
  localparam int PHASE_LEN = 8;
`else
  localparam int PHASE_LEN = 4;
`endif

  function automatic logic [3:0] phase_pattern(input logic [PHASE_W-1:0] idx);
    if (PHASE_LEN == 8) return HALF_TABLE[{idx, 2'b00} +: 4];
    return WAVE_TABLE[{idx[1:0], 2'b00} +: 4];
  endfunction

  function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] idx,
                                                    input logic fwd);
    if (fwd) return (idx == PHASE_W'(PHASE_LEN - 1)) ? '0 : idx + PHASE_W'(1);
    return (idx == '0) ? PHASE_W'(PHASE_LEN - 1) : idx - PHASE_W'(1);
  endfunction

endpackage

// File: rtl/stepper_step_scheduler_delay.sv
// Inter-step delay down-counter: load has priority, decrements while enabled, stops at zero.
module step_delay_counter #(
  parameter int DELAY_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_value,
  input  logic               enable,
  output logic               zero
);

  logic [DELAY_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - DELAY_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/stepper_step_scheduler.sv
// Stepper move scheduler: accepts move commands and issues coil phase steps at a fixed period.
// Build macro STEPPER_HALF_STEP_EN (see stepper_pkg) selects half-step vs wave drive.
module stepper_step_scheduler
  import stepper_pkg::*;
#(
  parameter int COUNT_W = 8,
  parameter int DELAY_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic               abort,
  output logic [3:0]         stepper_signals,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] steps_remaining
);

  state_e             state;
  logic               dir;
  logic [DELAY_W-1:0] delay_eff;
  logic [DELAY_W-1:0] cnt_value;
  logic [PHASE_W-1:0] phase_idx;
  logic [PHASE_W-1:0] phase_nxt;
  logic               zero_pending;
  logic               cnt_load;
  logic               cnt_enable;
  logic               cnt_zero;
  logic               accept;

  assign cmd_ready = (state == ST_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign phase_nxt = next_phase(phase_idx, dir);

  // The final step waits one extra cycle so done lands a full period after the last update.
  always_comb begin
    cnt_load   = 1'b0;
    cnt_value  = '0;
    cnt_enable = (state == ST_WAIT);
    if (busy && abort) begin
      cnt_load = 1'b1;
    end else if (state == ST_STEP) begin
      cnt_load  = 1'b1;
      cnt_value = (steps_remaining == COUNT_W'(1)) ? delay_eff - DELAY_W'(1)
                                                    : delay_eff - DELAY_W'(MIN_DELAY);
    end
  end

  step_delay_counter #(.DELAY_W(DELAY_W)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .enable     (cnt_enable),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      dir             <= 1'b0;
      delay_eff       <= DELAY_W'(MIN_DELAY);
      phase_idx       <= '0;
      stepper_signals <= phase_pattern('0);
      steps_remaining <= '0;
      zero_pending    <= 1'b0;
      done            <= 1'b0;
    end else begin
      done         <= zero_pending;
      zero_pending <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir             <= cmd_dir;
            delay_eff       <= (cmd_delay < DELAY_W'(MIN_DELAY)) ? DELAY_W'(MIN_DELAY) : cmd_delay;
            steps_remaining <= cmd_steps;
            if (cmd_steps != '0) state <= ST_STEP;
            else zero_pending <= 1'b1;
          end
        end
        ST_STEP: begin
          phase_idx       <= phase_nxt;
          stepper_signals <= phase_pattern(phase_nxt);
          if (abort) begin
            state           <= ST_IDLE;
            steps_remaining <= '0;
          end else begin
            state           <= ST_WAIT;
            steps_remaining <= steps_remaining - COUNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state           <= ST_IDLE;
            steps_remaining <= '0;
          end else if (cnt_zero) begin
            if (steps_remaining != '0) begin
              state <= ST_STEP;
            end else begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stepper_step_scheduler.md
STEPPER_STEP_SCHEDULER -- requirements
Module: stepper_step_scheduler

Interface
REQ-001 Parameter COUNT_W, default 8: width of the step count and steps_remaining.
REQ-002 Parameter DELAY_W, default 24: width of the per-step delay in clk cycles.
REQ-003 clk  in  1  single clock for the block; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  requester offers a move command.
REQ-006 cmd_ready  out  1  scheduler can accept a command this cycle.
REQ-007 cmd_dir  in  1  1 = forward (phase index +1), 0 = reverse (phase index -1).
REQ-008 cmd_steps  in  COUNT_W  number of steps to issue.
REQ-009 cmd_delay  in  DELAY_W  step period D in clk cycles.
REQ-010 abort  in  1  cancel the move in progress.
REQ-011 stepper_signals  out  4  registered coil drive pattern.
REQ-012 busy  out  1  a move is in progress (state STEP or WAIT).
REQ-013 done  out  1  one-cycle pulse when a move completes normally.
REQ-014 steps_remaining  out  COUNT_W  steps of the current move not yet issued.

Function
REQ-015 The FSM SHALL have the states IDLE, STEP and WAIT.
REQ-016 cmd_ready SHALL equal (state==IDLE && !abort); a command is accepted on a clock edge where cmd_valid && cmd_ready.
REQ-017 On acceptance the block SHALL latch dir, D_eff = max(cmd_delay, 2) and steps_remaining = cmd_steps, and go to STEP; if cmd_steps==0 it SHALL stay in IDLE and pulse done in the next cycle.
REQ-018 STEP SHALL last exactly 1 cycle: at its end the phase index moves by ±1 modulo the table length, steps_remaining decrements, the delay counter loads D_eff-2, and the state goes to WAIT.
REQ-019 WAIT SHALL decrement the delay counter each cycle; at count 0 it goes to STEP if steps_remaining>0, otherwise to IDLE with done high for exactly that first IDLE cycle.
REQ-020 Timing: with acceptance at edge 0, phase updates occur at edges 1, 1+D_eff, ..., 1+(N-1)·D_eff, and done is high in the cycle starting at edge 1+N·D_eff.
REQ-021 stepper_signals SHALL be a registered lookup of the phase index, with no combinational path from any input.
REQ-022 The phase index SHALL persist across commands; no move resets it, so motor position stays continuous.
REQ-023 abort in STEP or WAIT SHALL force IDLE on the next edge, clear steps_remaining and hold the phase; done SHALL NOT pulse. An abort in the same edge as a STEP update lets that update occur.
REQ-024 abort in IDLE SHALL have no effect except deasserting cmd_ready; an abort coinciding with cmd_valid rejects the command.
REQ-025 cmd_valid while busy SHALL be ignored, and the requester holds it until cmd_ready.

Reset
REQ-026 reset SHALL override all inputs, including in mid-move: state=IDLE, phase index=0, stepper_signals=4'b0001, steps_remaining=0, delay counter=0, busy=0, done=0, cmd_ready=1 from the first cycle after reset.

Configuration
REQ-027 Macro STEPPER_HALF_STEP_EN defined: 8-entry half-step table 0001,0011,0010,0110,0100,1100,1000,1001, index modulo 8.
REQ-028 Macro STEPPER_HALF_STEP_EN undefined: 4-entry wave table 0001,0010,0100,1000, index modulo 4. All timing is identical in both builds.

Structure
REQ-029 Shared package stepper_pkg SHALL hold the FSM state enum, both phase tables, the table-length constant selected by STEPPER_HALF_STEP_EN, and MIN_DELAY=2.
REQ-030 The delay counter SHALL be a separate sub-module, step_delay_counter, with load, enable and zero-flag ports; everything else stays in stepper_step_scheduler.

Verification
REQ-031 Reset, then cmd dir=1, steps=3, D=4 accepted at edge 0 (wave build) -> stepper_signals 0010@e1, 0100@e5, 1000@e9; done single pulse @e13; busy high e1..e12.
REQ-032 Then dir=0, steps=2, D=0 (treated as 2) -> 0100@e1, 0010@e3; done @e5; phase continuity from the previous move.
REQ-033 Wave build, dir=1, steps=5 from phase 1000 -> wraps to 0001 at the first update; repeat with STEPPER_HALF_STEP_EN, 9 steps from 0001 -> wraps 1001->0001.
REQ-034 steps=0 command -> no phase change, busy stays 0, done pulses in the next cycle.
REQ-035 abort at cycle 6 of a steps=10, D=4 move -> IDLE next edge, steps_remaining=0, no done, phase held, cmd_ready=1 one cycle later; cmd_valid+abort together in IDLE -> not accepted.
REQ-036 reset asserted mid-WAIT -> next cycle stepper_signals=0001, busy=0, steps_remaining=0; cmd_valid held during busy is accepted only once IDLE is reached.
